// File: rtl/ysyx_040750_pkg.sv
// ysyx_040750_pkg: default regfile dimensions and packed-bus width helpers
package ysyx_040750_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  function automatic int bus_w(input int n, input int w);
    return n * w;
  endfunction
endpackage

// File: rtl/ysyx_040750_scoreboard.sv
// ysyx_040750_scoreboard: per-register pending bits set by alloc, cleared by writeback or flush
module ysyx_040750_scoreboard
  import ysyx_040750_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                    I_sys_clk,
  input  logic                    I_rst_n,
  input  logic [NWR-1:0]          I_wen,
  input  logic [bus_w(NWR,AW)-1:0] I_wr_addr,
  input  logic [bus_w(NRD,AW)-1:0] I_rd_addr,
  input  logic                    I_alloc_valid,
  input  logic [AW-1:0]           I_alloc_addr,
  input  logic                    I_flush,
  output logic [NRD-1:0]          O_rd_busy
);
  logic [NREG-1:0] busy, busy_nxt, wr_hit, al_hit;
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NWR; k++) if (I_wen[k]) wr_hit[I_wr_addr[k*AW +: AW]] = 1'b1;
    al_hit = '0;
    al_hit[I_alloc_addr] = I_alloc_valid;
    busy_nxt = I_flush ? '0 : (busy & ~wr_hit) | al_hit;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge I_sys_clk or negedge I_rst_n)
    if (!I_rst_n) busy <= '0;
    else busy <= busy_nxt;
  // busy[0] is never set, so address 0 reads not-busy without a special case
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = I_rd_addr[p*AW +: AW];
    assign O_rd_busy[p] = busy[a] & ~(wr_hit[a] & ~al_hit[a]);
  end
endmodule

// File: rtl/ysyx_040750_regfile_sb.sv
// ysyx_040750_regfile_sb: multi-port register file with write-first bypass and scoreboard
module ysyx_040750_regfile_sb
  import ysyx_040750_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                      I_sys_clk,
  input  logic                      I_rst_n,
  input  logic [NWR-1:0]            I_wen,
  input  logic [bus_w(NWR,AW)-1:0]   I_wr_addr,
  input  logic [bus_w(NWR,XLEN)-1:0] I_wr_data,
  input  logic [bus_w(NRD,AW)-1:0]   I_rd_addr,
  output logic [bus_w(NRD,XLEN)-1:0] O_rd_data,
  output logic [NRD-1:0]            O_rd_busy,
  input  logic                      I_alloc_valid,
  input  logic [AW-1:0]             I_alloc_addr,
  input  logic                      I_flush
);
  logic [XLEN-1:0] regs [NREG];
  // ascending port order lets the highest-index port win same-address writes
  always_ff @(posedge I_sys_clk or negedge I_rst_n)
    if (!I_rst_n) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else
      for (int k = 0; k < NWR; k++)
        if (I_wen[k] && I_wr_addr[k*AW +: AW] != '0) regs[I_wr_addr[k*AW +: AW]] <= I_wr_data[k*XLEN +: XLEN];
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    assign a = I_rd_addr[p*AW +: AW];
    always_comb begin
      v = regs[a];
      for (int k = 0; k < NWR; k++) v = (I_wen[k] && I_wr_addr[k*AW +: AW] == a) ? I_wr_data[k*XLEN +: XLEN] : v;
    end
    assign O_rd_data[p*XLEN +: XLEN] = (I_rst_n && a != '0) ? v : '0;
  end
  ysyx_040750_scoreboard #(.NREG(NREG), .NRD(NRD), .NWR(NWR), .AW(AW)) u_sb (
    .I_sys_clk    (I_sys_clk),
    .I_rst_n      (I_rst_n),
    .I_wen        (I_wen),
    .I_wr_addr    (I_wr_addr),
    .I_rd_addr    (I_rd_addr),
    .I_alloc_valid(I_alloc_valid),
    .I_alloc_addr (I_alloc_addr),
    .I_flush      (I_flush),
    .O_rd_busy    (O_rd_busy)
  );
endmodule

// File: tb/tb_ysyx_040750_regfile_sb.sv
// tb_ysyx_040750_regfile_sb: directed and randomized checks against an array-based model
module tb_ysyx_040750_regfile_sb;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [1:0]   wen = 0;
  logic [9:0]   wr_addr = 0;
  logic [127:0] wr_data = 0;
  logic [9:0]   rd_addr = 0;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         alloc_valid = 0;
  logic [4:0]   alloc_addr = 0;
  logic         flush = 0;
  int total = 0, bad = 0;
  logic [63:0] mregs [32];
  logic        mbusy [32];

  always #5 clk = ~clk;

  ysyx_040750_regfile_sb dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_wen(wen), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
    .I_rd_addr(rd_addr), .O_rd_data(rd_data), .O_rd_busy(rd_busy),
    .I_alloc_valid(alloc_valid), .I_alloc_addr(alloc_addr), .I_flush(flush)
  );

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    logic [63:0] v;
    if (!rst_n || a == 0) return 64'd0;
    v = mregs[a];
    for (int k = 0; k < 2; k++) if (wen[k] && wr_addr[k*5 +: 5] == a) v = wr_data[k*64 +: 64];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic w;
    w = 0;
    if (!rst_n || a == 0) return 1'b0;
    for (int k = 0; k < 2; k++) if (wen[k] && wr_addr[k*5 +: 5] == a) w = 1;
    return mbusy[a] && !(w && !(alloc_valid && alloc_addr == a));
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = 0;
      mbusy[r] = 0;
    end
  endtask

  task automatic model_clk();
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) if (wen[k] && wr_addr[k*5 +: 5] != 0) mregs[wr_addr[k*5 +: 5]] = wr_data[k*64 +: 64];
    for (int r = 1; r < 32; r++) begin
      for (int k = 0; k < 2; k++) if (wen[k] && wr_addr[k*5 +: 5] == r) mbusy[r] = 0;
      if (alloc_valid && alloc_addr == r) mbusy[r] = 1;
      if (flush) mbusy[r] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic idle();
    wen = 0;
    alloc_valid = 0;
    flush = 0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [63:0] d);
    wen = 2'b01;
    wr_addr[4:0] = a;
    wr_data[63:0] = d;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 0;
    wr0(5'd3, 64'h1234);
    alloc_valid = 1;
    alloc_addr = 5'd3;
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(i + 16), 5'(i)};
      #1;
      total++;
      if (rd_data !== 128'd0) begin bad++; $display("FAIL reset_data x%0d/x%0d: got %h want 0", i, i + 16, rd_data); end
      total++;
      if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy x%0d/x%0d: got %b want 00", i, i + 16, rd_busy); end
      tick();
    end
    idle();
    rst_n = 1;
    rd_addr = {5'd3, 5'd3};
    #1;
    total++;
    if (rd_data[63:0] !== 64'd0 || rd_busy[0] !== 1'b0) begin bad++; $display("FAIL reset_ignored_ops: got %h/%b want 0/0", rd_data[63:0], rd_busy[0]); end
    tick();
  endtask

  task automatic test_bypass();
    rd_addr[4:0] = 5'd5;
    wr0(5'd5, 64'hDEAD_BEEF);
    #1;
    total++;
    if (rd_data[63:0] !== 64'hDEAD_BEEF) begin bad++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rd_data[63:0]); end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (rd_data[63:0] !== 64'hDEAD_BEEF) begin bad++; $display("FAIL bypass_hold[%0d]: got %h want deadbeef", i, rd_data[63:0]); end
      tick();
    end
  endtask

  task automatic test_multi_write();
    wen = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {64'd2, 64'd1};
    rd_addr = {5'd7, 5'd7};
    #1;
    total++;
    if (rd_data !== {64'd2, 64'd2}) begin bad++; $display("FAIL multi_bypass: got %h want 2/2", rd_data); end
    tick();
    idle();
    #1;
    total++;
    if (rd_data[63:0] !== 64'd2) begin bad++; $display("FAIL multi_array: got %h want 2", rd_data[63:0]); end
    wr0(5'd0, 64'hFF);
    rd_addr[4:0] = 5'd0;
    #1;
    total++;
    if (rd_data[63:0] !== 64'd0) begin bad++; $display("FAIL x0_bypass: got %h want 0", rd_data[63:0]); end
    tick();
    idle();
    #1;
    total++;
    if (rd_data[63:0] !== 64'd0) begin bad++; $display("FAIL x0_array: got %h want 0", rd_data[63:0]); end
  endtask

  task automatic test_alloc();
    alloc_valid = 1;
    alloc_addr = 5'd3;
    rd_addr[4:0] = 5'd3;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL alloc_busy: got %b want 1", rd_busy[0]); end
    wr0(5'd3, 64'd9);
    #1;
    total++;
    if (rd_busy[0] !== 1'b0 || rd_data[63:0] !== 64'd9) begin bad++; $display("FAIL wb_bypass: got busy=%b data=%h want 0/9", rd_busy[0], rd_data[63:0]); end
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0 || rd_data[63:0] !== 64'd9) begin bad++; $display("FAIL wb_after: got busy=%b data=%h want 0/9", rd_busy[0], rd_data[63:0]); end
    alloc_valid = 1;
    alloc_addr = 5'd0;
    rd_addr[4:0] = 5'd0;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL x0_never_busy: got %b want 0", rd_busy[0]); end
  endtask

  task automatic test_alloc_write_flush();
    alloc_valid = 1;
    alloc_addr = 5'd4;
    wr0(5'd4, 64'd6);
    rd_addr[4:0] = 5'd4;
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL alloc_wr_pre: got %b want 0", rd_busy[0]); end
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || rd_data[63:0] !== 64'd6) begin bad++; $display("FAIL alloc_wins: got busy=%b data=%h want 1/6", rd_busy[0], rd_data[63:0]); end
    flush = 1;
    alloc_valid = 1;
    alloc_addr = 5'd4;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL flush_clears: got %b want 0", rd_busy[0]); end
  endtask

  task automatic test_async_reset();
    alloc_valid = 1;
    alloc_addr = 5'd8;
    tick();
    wr0(5'd8, 64'h11);
    alloc_addr = 5'd9;
    tick();
    idle();
    rd_addr = {5'd9, 5'd8};
    #1;
    total++;
    if (rd_data[63:0] !== 64'h11 || rd_busy !== 2'b10) begin bad++; $display("FAIL pre_reset: got data=%h busy=%b want 11/10", rd_data[63:0], rd_busy); end
    #1;
    rst_n = 0;
    model_clear();
    #1;
    total++;
    if (rd_data !== 128'd0 || rd_busy !== 2'b00) begin bad++; $display("FAIL async_reset: got data=%h busy=%b want 0/00", rd_data, rd_busy); end
    @(negedge clk);
    rst_n = 1;
    #1;
    total++;
    if (rd_data !== 128'd0 || rd_busy !== 2'b00) begin bad++; $display("FAIL post_reset: got data=%h busy=%b want 0/00", rd_data, rd_busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wen = 2'($urandom);
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      alloc_valid = 1'($urandom);
      alloc_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < 2; p++) begin
        total++;
        if (rd_data[p*64 +: 64] !== exp_data(rd_addr[p*5 +: 5])) begin
          bad++;
          $display("FAIL rand_data c%0d p%0d x%0d: got %h want %h", c, p, rd_addr[p*5 +: 5], rd_data[p*64 +: 64], exp_data(rd_addr[p*5 +: 5]));
        end
        total++;
        if (rd_busy[p] !== exp_busy(rd_addr[p*5 +: 5])) begin
          bad++;
          $display("FAIL rand_busy c%0d p%0d x%0d: got %b want %b", c, p, rd_addr[p*5 +: 5], rd_busy[p], exp_busy(rd_addr[p*5 +: 5]));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_bypass();
    test_multi_write();
    test_alloc();
    test_alloc_write_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
